// File: rtl/rst_seq_pkg.sv
// Shared types and sizing helpers for the reset sequencer and its synchronizer.
`timescale 1ns/1ps

package rst_seq_pkg;

    typedef enum logic [1:0] {
        RST   = 2'd0,
        HOLD  = 2'd1,
        STAGE = 2'd2,
        DONE  = 2'd3
    } seq_state_e;

    localparam int SYNC_STAGES = 2;

    // Smallest counter that can hold the longer of the two delays.
    function automatic int cnt_width(input int hold_cycles, input int stage_dly);
        int longest;
        longest = (hold_cycles > stage_dly) ? hold_cycles : stage_dly;
        return $clog2(longest + 1);
    endfunction

endpackage

// File: rtl/rst_sync_2ff.sv
// Two-flop reset synchronizer: asserts asynchronously with rstn_async, releases on the
// second clk edge after rstn_async goes high.
`timescale 1ns/1ps

module rst_sync_2ff
    import rst_seq_pkg::*;
(
    input  logic clk,
    input  logic rstn_async,
    output logic rst_sync
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], 1'b1};
    end

    always_ff @(posedge clk or negedge rstn_async) begin
        if (!rstn_async) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign rst_sync = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// Multi-domain reset controller: holds every domain in reset, then releases them one at a
// time in index order, and supports a software re-reset once the sequence has completed.
`timescale 1ns/1ps

module reset_sequencer
    import rst_seq_pkg::*;
#(
    parameter int NUM_DOMAINS = 4,
    parameter int HOLD_CYCLES = 8,
    parameter int STAGE_DLY   = 16
) (
    input  logic                   clk,
    input  logic                   rstn_async,
    input  logic                   sw_rst_req,
    output logic [NUM_DOMAINS-1:0] domain_rstn,
    output logic                   busy,
    output logic                   seq_done
);

    localparam int CNT_W = cnt_width(HOLD_CYCLES, STAGE_DLY);
    localparam int IDX_W = $clog2(NUM_DOMAINS) + 1;

    localparam logic [CNT_W-1:0]       HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0]       STAGE_LAST = CNT_W'(STAGE_DLY - 1);
    localparam logic [IDX_W-1:0]       IDX_LAST   = IDX_W'(NUM_DOMAINS - 1);
    localparam logic [NUM_DOMAINS-1:0] DOM_FIRST  = NUM_DOMAINS'(1);

    if (NUM_DOMAINS < 1 || HOLD_CYCLES < 1 || STAGE_DLY < 1) begin : g_bad_params
        $error("reset_sequencer: NUM_DOMAINS, HOLD_CYCLES and STAGE_DLY must all be >= 1");
    end

    logic rst_sync;

    rst_sync_2ff u_rst_sync (
        .clk        (clk),
        .rstn_async (rstn_async),
        .rst_sync   (rst_sync)
    );

    seq_state_e             state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [NUM_DOMAINS-1:0] dom_q, dom_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        dom_d   = dom_q;

        case (state_q)
            RST: begin
                // Only seen for the single cycle T0; that cycle is the first hold cycle.
                idx_d = '0;
                dom_d = '0;
                if (HOLD_CYCLES == 1) begin
                    state_d = STAGE;
                    cnt_d   = '0;
                    dom_d   = DOM_FIRST;
                end else begin
                    state_d = HOLD;
                    cnt_d   = CNT_W'(1);
                end
            end

            HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    state_d = STAGE;
                    cnt_d   = '0;
                    idx_d   = '0;
                    dom_d   = DOM_FIRST;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            STAGE: begin
                if (cnt_q == STAGE_LAST) begin
                    cnt_d = '0;
                    if (idx_q == IDX_LAST) begin
                        state_d = DONE;
                    end else begin
                        // Releases are strictly in order, so the mask is a thermometer code.
                        idx_d = idx_q + IDX_W'(1);
                        dom_d = (dom_q << 1) | DOM_FIRST;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            DONE: begin
                if (sw_rst_req) begin
                    state_d = HOLD;
                    cnt_d   = '0;
                    idx_d   = '0;
                    dom_d   = '0;
                end
            end

            default: begin
                state_d = RST;
                cnt_d   = '0;
                idx_d   = '0;
                dom_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_sync) begin
        if (!rst_sync) begin
            state_q <= RST;
            cnt_q   <= '0;
            idx_q   <= '0;
            dom_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            dom_q   <= dom_d;
        end
    end

    assign domain_rstn = dom_q;
    assign busy        = (state_q != DONE);
    assign seq_done    = (state_q == DONE);

endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench for reset_sequencer with 3 domains, hold of 4 and stage spacing of 3.
`timescale 1ns/1ps

module tb_reset_sequencer;

    typedef struct {
        logic [2:0] dom;
        logic       busy;
        logic       done;
        int         cyc;
        bit         chk_t;
        time        tm;
        string      name;
    } exp_t;

    logic       clk = 1'b0;
    logic       rstn_async;
    logic       sw_rst_req;
    logic [2:0] domain_rstn;
    logic       busy;
    logic       seq_done;

    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    exp_t exp_q[$];
    event probe_ev;

    reset_sequencer #(
        .NUM_DOMAINS (3),
        .HOLD_CYCLES (4),
        .STAGE_DLY   (3)
    ) dut (
        .clk         (clk),
        .rstn_async  (rstn_async),
        .sw_rst_req  (sw_rst_req),
        .domain_rstn (domain_rstn),
        .busy        (busy),
        .seq_done    (seq_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic push_exp(input logic [2:0] d, input logic b, input logic dn, input int c,
                            input bit ct, input time tm, input string nm);
        exp_t e;
        e.dom = d; e.busy = b; e.done = dn; e.cyc = c; e.chk_t = ct; e.tm = tm; e.name = nm;
        exp_q.push_back(e);
    endtask

    // Expected output events of a sequence whose start edge leaves cyc == e0.
    task automatic push_seq(input int e0, input int n, input string nm);
        if (n > 0) push_exp(3'b001, 1'b1, 1'b0, e0 + 4,  1'b0, 0, {nm, "_rel0"});
        if (n > 1) push_exp(3'b011, 1'b1, 1'b0, e0 + 7,  1'b0, 0, {nm, "_rel1"});
        if (n > 2) push_exp(3'b111, 1'b1, 1'b0, e0 + 10, 1'b0, 0, {nm, "_rel2"});
        if (n > 3) push_exp(3'b111, 1'b0, 1'b1, e0 + 13, 1'b0, 0, {nm, "_done"});
    endtask

    task automatic chk_empty(input string nm);
        n_chk++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s: %0d expected output events never seen, required 0 (next %s)",
                     nm, exp_q.size(), exp_q[0].name);
            exp_q.delete();
        end
    endtask

    // Monitor: every output change (or explicit probe) consumes one expectation.
    initial begin
        time  t_trig;
        exp_t e;
        #3;
        forever begin
            @(domain_rstn or busy or seq_done or probe_ev);
            t_trig = $time;
            #0.2;
            n_chk++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_change: got dom=%b busy=%b done=%b cyc=%0d t=%0t, required no change",
                         domain_rstn, busy, seq_done, cyc, t_trig);
            end else begin
                e = exp_q.pop_front();
                if (domain_rstn !== e.dom || busy !== e.busy || seq_done !== e.done ||
                    cyc != e.cyc || (e.chk_t && t_trig != e.tm)) begin
                    n_fail++;
                    $display("FAIL %s: got dom=%b busy=%b done=%b cyc=%0d t=%0t, required dom=%b busy=%b done=%b cyc=%0d t=%0t",
                             e.name, domain_rstn, busy, seq_done, cyc, t_trig,
                             e.dom, e.busy, e.done, e.cyc, e.chk_t ? e.tm : t_trig);
                end
            end
        end
    end

    initial begin
        int c;
        int s;
        rstn_async = 1'b1;
        sw_rst_req = 1'b0;
        #2 rstn_async = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        push_exp(3'b000, 1'b1, 1'b0, cyc, 1'b0, 0, "reset_state");
        -> probe_ev;

        // 1: power-up release
        @(negedge clk);
        c = cyc;
        push_seq(c + 2, 4, "powerup");
        rstn_async = 1'b1;
        repeat (18) @(negedge clk);
        chk_empty("powerup_complete");

        // 6: 1 ns glitch on rstn_async while in DONE
        #2;
        push_exp(3'b000, 1'b1, 1'b0, cyc, 1'b1, $time, "glitch_clear");
        rstn_async = 1'b0;
        #1 rstn_async = 1'b1;
        c = cyc;
        push_seq(c + 2, 1, "glitch_reseq");

        // 2: abort while domain_rstn == 001
        @(negedge clk);
        repeat (5) @(negedge clk);
        #2;
        push_exp(3'b000, 1'b1, 1'b0, cyc, 1'b1, $time, "abort_clear");
        rstn_async = 1'b0;
        @(negedge clk);
        @(negedge clk);
        c = cyc;
        push_seq(c + 2, 4, "abort_reseq");
        rstn_async = 1'b1;
        repeat (18) @(negedge clk);
        chk_empty("abort_complete");

        // 3: single-cycle SW request in DONE
        c = cyc;
        push_exp(3'b000, 1'b1, 1'b0, c + 1, 1'b0, 0, "sw_clear");
        push_seq(c + 1, 4, "sw_seq");
        sw_rst_req = 1'b1;
        @(negedge clk);
        sw_rst_req = 1'b0;
        repeat (16) @(negedge clk);
        chk_empty("sw_complete");

        // 4: requests during HOLD and STAGE are ignored
        c = cyc;
        push_exp(3'b000, 1'b1, 1'b0, c + 1, 1'b0, 0, "ign_clear");
        push_seq(c + 1, 4, "ign_seq");
        sw_rst_req = 1'b1;
        @(negedge clk);
        sw_rst_req = 1'b0;
        @(negedge clk);
        sw_rst_req = 1'b1;
        repeat (10) @(negedge clk);
        sw_rst_req = 1'b0;
        repeat (28) @(negedge clk);
        chk_empty("ign_complete");

        // 5: request held high loops the sequence
        c = cyc;
        s = c + 1;
        for (int k = 0; k < 3; k++) begin
            push_exp(3'b000, 1'b1, 1'b0, s + 14 * k, 1'b0, 0, $sformatf("held_clear%0d", k));
            push_seq(s + 14 * k, 4, $sformatf("held_loop%0d", k));
        end
        sw_rst_req = 1'b1;
        repeat (36) @(negedge clk);
        sw_rst_req = 1'b0;
        repeat (20) @(negedge clk);
        chk_empty("held_complete");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
- Reset controller for a multi-domain subsystem.
- Takes the board-level asynchronous reset and synchronizes its deassertion to clk.
- Releases NUM_DOMAINS downstream reset outputs one at a time, in fixed order, with programmed spacing between releases.
- Supports a software-requested re-reset of all domains once a sequence has finished.

Parameters:
- NUM_DOMAINS, 4: number of sequenced reset outputs (>=1).
- HOLD_CYCLES, 8: clk cycles all domains are held in reset after the synchronized reset goes high, or after a SW request is accepted (>=1).
- STAGE_DLY, 16: clk cycles between successive domain releases, and from the last release to seq_done (>=1).

Ports:
- clk  input  1  system clock.
- rstn_async  input  1  reset, asynchronous, active-low.
- sw_rst_req  input  1  software reset request, synchronous to clk, level-sampled.
- domain_rstn  output  NUM_DOMAINS  per-domain active-low reset; bit 0 is released first.
- busy  output  1  high while a sequence is in progress or reset is held.
- seq_done  output  1  high once all domains are released and the settle time has elapsed.

Behaviour:
- Async assert:
  - rstn_async low immediately (no clock) forces domain_rstn=0, busy=1, seq_done=0, FSM=RST.
  - All state flops clear asynchronously; they use the synchronized reset except the synchronizer itself.
- Synchronizer:
  - Two flops, async-cleared by rstn_async, shifting in 1.
  - rst_sync goes high on the 2nd posedge after rstn_async deasserts.
  - T0 is the first cycle in which rst_sync=1.
- FSM states:
  - RST: rst_sync low; outputs as in async assert.
  - HOLD: counter counts HOLD_CYCLES; all domain_rstn=0.
  - STAGE: index i from 0 to NUM_DOMAINS-1.
    - domain_rstn[i] set on entry.
    - Counter counts STAGE_DLY before advancing to i+1, or to DONE after the last domain.
  - DONE: seq_done=1, busy=0.
- Release timing:
  - domain_rstn[i] rises at the edge ending cycle T0+HOLD_CYCLES+i*STAGE_DLY-1.
  - seq_done rises STAGE_DLY cycles after domain_rstn[NUM_DOMAINS-1].
  - busy falls on the same edge that seq_done rises.
- Monotonic release: once released, domain_rstn[i] stays high until async reset or an accepted SW request.
- SW request:
  - Sampled only in DONE.
  - If sw_rst_req=1 at a posedge in DONE, on that edge: all domain_rstn->0, seq_done->0, busy->1, FSM->HOLD.
  - The full sequence then repeats, with that edge taking the role of the T0 start.
- SW request outside DONE: ignored, neither queued nor extending the sequence.
- SW request held high: re-triggers on every entry to DONE. One cycle of seq_done=1 is visible each time.
- rstn_async asserted mid-sequence or mid-HOLD: immediate abort to RST, full restart on release.
- Counter:
  - Width $clog2(max(HOLD_CYCLES,STAGE_DLY)+1).
  - Reloads to 0 on every state or stage change; no wrap is possible.
- Stage index: width $clog2(NUM_DOMAINS)+1.
- Assertions: HOLD_CYCLES>=1, STAGE_DLY>=1, NUM_DOMAINS>=1, checked in an elaboration-time generate check.

Decomposition:
- Package rst_seq_pkg holds:
  - FSM state enum {RST, HOLD, STAGE, DONE};
  - a counter-width helper function.
- Sub-module rst_sync_2ff holds the 2-flop async-assert/sync-deassert synchronizer. It is instantiated once; its output is the internal reset of the FSM.
- Everything else lives in reset_sequencer.

Test Plan:
All scenarios use NUM_DOMAINS=3, HOLD=4, STAGE=3.
1. Power-up: release rstn_async.
   - rst_sync high after 2 edges.
   - domain_rstn goes 000 -> 001 at T0+3 -> 011 at T0+6 -> 111 at T0+9.
   - seq_done=1, busy=0 at T0+12.
2. Mid-sequence abort: drive rstn_async low asynchronously while domain_rstn=001.
   - domain_rstn=000 and busy=1 within the same timestep, no clock edge.
   - Re-release replays scenario 1 timing exactly.
3. SW reset: in DONE, pulse sw_rst_req for 1 cycle.
   - Next edge: domain_rstn=000, seq_done=0.
   - Releases follow at +4, +7, +10; seq_done at +13.
4. Ignored request: assert sw_rst_req during HOLD and STAGE only, deasserted before DONE.
   - Sequence timing unchanged; DONE is reached and stays.
5. Held request: keep sw_rst_req=1 continuously.
   - Sequence repeats indefinitely with one seq_done=1 cycle per loop.
   - domain_rstn never releases out of order.
6. Glitch: 1-ns low pulse on rstn_async between clock edges while in DONE.
   - All outputs clear.
   - Full re-sequence matches scenario 1.
